// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 shift-add multiplier among NREQ requesters.
// Define MULT_SHARE_ARB_FAST_EN to re-arbitrate on the response handshake (one op per 2 cycles).
module mult_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [2*DATA_W-1:0]    resp_product,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [ID_W-1:0]               rr_ptr_q, id_q, resp_id_q, gnt_idx;
  logic [DATA_W-1:0]             a_q, b_q;
  logic [2*DATA_W-1:0]           prod_q;
  logic                          resp_valid_q, gnt_found, arb_en, gnt;
  logic [NREQ-1:0][DATA_W-1:0]   a_arr, b_arr;

  assign a_arr = req_a;
  assign b_arr = req_b;

  function automatic logic [2*DATA_W-1:0] mul(input logic [DATA_W-1:0] x,
                                              input logic [DATA_W-1:0] y);
    logic [2*DATA_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DATA_W; i++)
      if (y[i]) acc = acc + ({{DATA_W{1'b0}}, x} << i);
    return acc;
  endfunction

  // First valid requester after the last winner, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

`ifdef MULT_SHARE_ARB_FAST_EN
  assign arb_en = (state_q == S_IDLE) || (state_q == S_RESP && resp_ready);
`else
  assign arb_en = (state_q == S_IDLE);
`endif
  assign gnt = arb_en && gnt_found;

  for (genvar i = 0; i < NREQ; i++) begin : g_rdy
    assign req_ready[i] = gnt && (gnt_idx == ID_W'(i));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt) state_d = S_CALC;
      S_CALC:  state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = gnt ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= ID_W'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      prod_q       <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        a_q      <= a_arr[gnt_idx];
        b_q      <= b_arr[gnt_idx];
        id_q     <= gnt_idx;
        rr_ptr_q <= gnt_idx;
      end
      if (state_q == S_CALC) begin
        prod_q       <= mul(a_q, b_q);
        resp_id_q    <= id_q;
        resp_valid_q <= 1'b1;
      end else if (state_q == S_RESP && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = prod_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: vector table plus multi-cycle corner sequences.
module tb_mult_share_arbiter;
  localparam int NREQ = 4, ID_W = 2, DW = 8;
`ifdef MULT_SHARE_ARB_FAST_EN
  localparam int SPACING = 2;
  localparam bit FAST = 1'b1;
`else
  localparam int SPACING = 3;
  localparam bit FAST = 1'b0;
`endif

  logic              clk, rst, resp_valid, resp_ready, busy;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [ID_W-1:0]   resp_id;
  logic [2*DW-1:0]   resp_product;

  mult_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_op(input int r, input logic [7:0] a, input logic [7:0] b);
    req_a[r*DW +: DW] = a;
    req_b[r*DW +: DW] = b;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  typedef struct { int r; logic [7:0] a; logic [7:0] b; logic [15:0] prod; } vec_t;
  vec_t vecs[5];

  logic [15:0] rr_exp[4];
  int rcyc[5], rid[5];
  logic [15:0] rprod[5];
  int nresp, got;
  logic [NREQ-1:0] prev_g;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2, 8'd12,  8'd11,  16'd132};
    vecs[1] = '{0, 8'd255, 8'd255, 16'd65025};
    vecs[2] = '{1, 8'd0,   8'd200, 16'd0};
    vecs[3] = '{3, 8'd1,   8'd173, 16'd173};
    vecs[4] = '{2, 8'd255, 8'd1,   16'd255};
    rr_exp  = '{16'd15, 16'd704, 16'd2379, 16'd5040};

    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    #12;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_prod", resp_product, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 1'b1;

    // Single-operation vectors: grant, one CALC cycle, response at T+2.
    foreach (vecs[i]) begin
      @(negedge clk);
      req_valid = '0; req_valid[vecs[i].r] = 1'b1; set_op(vecs[i].r, vecs[i].a, vecs[i].b);
      #1 chk("vec_grant", req_ready, 1 << vecs[i].r);
      @(negedge clk); req_valid = '0;
      #1 chk("vec_calc", {resp_valid, busy}, 2'b01);
      @(negedge clk);
      #1 chk("vec_rvalid", resp_valid, 1);
      chk("vec_id", resp_id, vecs[i].r);
      chk("vec_prod", resp_product, vecs[i].prod);
      @(negedge clk);
      #1 chk("vec_done", resp_valid, 0);
    end

    // Round-robin with all requesters continuously valid.
    pulse_reset();
    set_op(0, 8'd5, 8'd3); set_op(1, 8'd22, 8'd32);
    set_op(2, 8'd39, 8'd61); set_op(3, 8'd56, 8'd90);
    req_valid = 4'b1111;
    nresp = 0; prev_g = '0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (req_ready != '0) begin
        chk("rr_onehot", $onehot(req_ready), 1);
        chk("rr_no_repeat", req_ready != prev_g, 1);
        prev_g = req_ready;
      end
      if (resp_valid && nresp < 5) begin
        rcyc[nresp] = c; rid[nresp] = resp_id; rprod[nresp] = resp_product;
        nresp++;
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("rr_count", nresp, 5);
    for (int i = 0; i < nresp; i++) begin
      chk("rr_id", rid[i], i % 4);
      chk("rr_prod", rprod[i], rr_exp[i % 4]);
      if (i > 0) chk("rr_spacing", rcyc[i] - rcyc[i-1], SPACING);
    end
    repeat (4) @(negedge clk);

    // Backpressure: stalled consumer holds the response and blocks grants.
    pulse_reset();
    resp_ready = 1'b0;
    req_valid = 4'b0010; set_op(1, 8'd200, 8'd3);
    #1 chk("bp_grant", req_ready, 4'b0010);
    @(negedge clk); req_valid = 4'b1000; set_op(3, 8'd9, 8'd9);
    #1 chk("bp_calc_ready", req_ready, 0);
    @(negedge clk);
    #1 chk("bp_rvalid", resp_valid, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1 chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_id", resp_id, 1);
      chk("bp_hold_prod", resp_product, 600);
      chk("bp_hold_ready", req_ready, 0);
    end
    @(negedge clk); resp_ready = 1'b1;
    #1 chk("bp_hs_ready", req_ready, FAST ? 4'b1000 : 4'b0000);
    @(negedge clk);
    #1 chk("bp_next_ready", req_ready, FAST ? 4'b0000 : 4'b1000);
    if (!FAST) @(negedge clk);
    req_valid = '0;
    got = 0;
    for (int c = 0; c < 6 && got == 0; c++) begin
      #1;
      if (resp_valid) begin
        got = 1;
        chk("bp_next_id", resp_id, 3);
        chk("bp_next_prod", resp_product, 81);
      end
      @(negedge clk);
    end
    chk("bp_next_seen", got, 1);
    repeat (2) @(negedge clk);

    // Asynchronous reset during CALC drops the operation.
    req_valid = 4'b0100; set_op(2, 8'd7, 8'd7);
    #1 chk("mr_grant", req_ready, 4'b0100);
    @(negedge clk); req_valid = '0;
    #1 chk("mr_busy", busy, 1);
    #2 rst = 1'b0;
    #1 chk("mr_valid", resp_valid, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_id", resp_id, 0);
    chk("mr_prod", resp_product, 0);
    chk("mr_ready", req_ready, 0);
    @(negedge clk); rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("mr_no_stale", {resp_valid, busy}, 2'b00);
      @(negedge clk);
    end
    req_valid = 4'b1001; set_op(0, 8'd2, 8'd3); set_op(3, 8'd4, 8'd5);
    #1 chk("mr_first_prio", req_ready, 4'b0001);
    @(negedge clk); req_valid = '0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
